// File: rtl/cordic_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cordic_arb_pkg
//  Description : Shared types and constants for the CORDIC time-sharing
//                arbiter. Holds the arbiter state encoding, the default
//                operand width and the CORDIC mode encodings carried on sel.
//  Revision    : 1.0 - initial release
// ============================================================================
package cordic_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam int DATA_W = 32;

    // Mode values carried on sel / cor_select
    localparam logic MODE_ROT = 1'b0;
    localparam logic MODE_VEC = 1'b1;

endpackage
`default_nettype wire

// File: rtl/cordic_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Interface   : cordic_arbiter_if
//  Description : Bundles the requester-side and core-side signals of the
//                CORDIC arbiter.
//                  requester side : req, sel, x_in/y_in/z_in (per requester)
//                                   grant, resp_valid (one-hot pulses)
//                                   x_out/y_out/z_out, resp_err (broadcast)
//                  core side      : cor_enable, cor_select, cor_x/y/z_in
//                                   cor_x/y/z_out, cor_done
//                master = arbiter view, slave = environment view.
//  Revision    : 1.0 - initial release
// ============================================================================
interface cordic_arbiter_if
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = cordic_arb_pkg::DATA_W
);
    logic [NUM_REQ-1:0]             req;
    logic [NUM_REQ-1:0]             sel;
    logic [NUM_REQ-1:0][DATA_W-1:0] x_in;
    logic [NUM_REQ-1:0][DATA_W-1:0] y_in;
    logic [NUM_REQ-1:0][DATA_W-1:0] z_in;
    logic [NUM_REQ-1:0]             grant;
    logic [NUM_REQ-1:0]             resp_valid;
    logic [DATA_W-1:0]              x_out;
    logic [DATA_W-1:0]              y_out;
    logic [DATA_W-1:0]              z_out;
    logic                           resp_err;

    logic                           cor_enable;
    logic                           cor_select;
    logic [DATA_W-1:0]              cor_x_in;
    logic [DATA_W-1:0]              cor_y_in;
    logic [DATA_W-1:0]              cor_z_in;
    logic [DATA_W-1:0]              cor_x_out;
    logic [DATA_W-1:0]              cor_y_out;
    logic [DATA_W-1:0]              cor_z_out;
    logic                           cor_done;

    modport master (
        input  req, sel, x_in, y_in, z_in,
        input  cor_x_out, cor_y_out, cor_z_out, cor_done,
        output grant, resp_valid, x_out, y_out, z_out, resp_err,
        output cor_enable, cor_select, cor_x_in, cor_y_in, cor_z_in
    );

    modport slave (
        output req, sel, x_in, y_in, z_in,
        output cor_x_out, cor_y_out, cor_z_out, cor_done,
        input  grant, resp_valid, x_out, y_out, z_out, resp_err,
        input  cor_enable, cor_select, cor_x_in, cor_y_in, cor_z_in
    );

endinterface
`default_nettype wire

// File: rtl/cordic_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
//  Module      : rr_picker
//  Description : Combinational round-robin selector. Returns the first set
//                bit of req at or after rr_ptr, wrapping around.
//                  req        in  [NUM_REQ] request vector
//                  rr_ptr     in  [IDX_W]   highest-priority position
//                  winner     out [NUM_REQ] one-hot winner (zero if no req)
//                  winner_idx out [IDX_W]   binary index of the winner
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_picker
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   rr_ptr,
    output logic      [NUM_REQ-1:0] winner,
    output logic      [IDX_W-1:0]   winner_idx
);

    localparam logic [IDX_W:0] C_NUM = (IDX_W+1)'(NUM_REQ);

    logic [IDX_W:0]   w_sum;
    logic [IDX_W-1:0] w_cand;
    logic             w_found;

    // Walk candidates rr_ptr, rr_ptr+1, ... modulo NUM_REQ; first hit wins.
    // rr_ptr and the offset are both below NUM_REQ, so one conditional
    // subtraction is enough to wrap.
    always_comb begin
        winner     = '0;
        winner_idx = '0;
        w_found    = 1'b0;
        w_sum      = '0;
        w_cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_sum = {1'b0, rr_ptr} + (IDX_W+1)'(i);
            if (w_sum >= C_NUM) begin
                w_sum = w_sum - C_NUM;
            end
            w_cand = w_sum[IDX_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found        = 1'b1;
                winner[w_cand] = 1'b1;
                winner_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cordic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : cordic_arbiter
//  Description : Time-shares one iterative CORDIC core between NUM_REQ
//                requesters. A round-robin winner's operands and mode are
//                registered, the core runs until cor_done or a watchdog
//                expiry, and the result returns with a one-cycle resp_valid
//                pulse to the granted requester.
//                  clk  in  clock
//                  rst  in  asynchronous active-high reset
//                  bus  cordic_arbiter_if.master (requester + core signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module cordic_arbiter
    import cordic_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = cordic_arb_pkg::DATA_W,
    parameter int TIMEOUT = 64
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cordic_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_BUSY = BUSY;
    localparam logic [1:0] S_RESP = RESP;

    localparam logic [WD_W-1:0]  C_WD_LAST  = WD_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_REQ - 1);

    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [WD_W-1:0]    r_wdog;
    logic [NUM_REQ-1:0] r_grant;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic               r_resp_err;
    logic               r_cor_enable;
    logic               r_cor_select;
    logic [DATA_W-1:0]  r_cor_x;
    logic [DATA_W-1:0]  r_cor_y;
    logic [DATA_W-1:0]  r_cor_z;
    logic [DATA_W-1:0]  r_x_out;
    logic [DATA_W-1:0]  r_y_out;
    logic [DATA_W-1:0]  r_z_out;

    logic [NUM_REQ-1:0] w_winner;
    logic [IDX_W-1:0]   w_winner_idx;
    logic               w_any_req;
    logic [NUM_REQ-1:0] w_owner_oh;

    assign w_any_req  = |bus.req;
    assign w_owner_oh = NUM_REQ'(1) << r_owner;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req        (bus.req),
        .rr_ptr     (r_rr_ptr),
        .winner     (w_winner),
        .winner_idx (w_winner_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_rr_ptr     <= '0;
            r_owner      <= '0;
            r_wdog       <= '0;
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_cor_enable <= 1'b0;
            r_cor_select <= 1'b0;
            r_cor_x      <= '0;
            r_cor_y      <= '0;
            r_cor_z      <= '0;
            r_x_out      <= '0;
            r_y_out      <= '0;
            r_z_out      <= '0;
        end else begin
            // grant / resp_valid / resp_err are single-cycle pulses
            r_grant      <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_cor_select <= bus.sel[w_winner_idx];
                        r_cor_x      <= bus.x_in[w_winner_idx];
                        r_cor_y      <= bus.y_in[w_winner_idx];
                        r_cor_z      <= bus.z_in[w_winner_idx];
                        r_grant      <= w_winner;
                        r_owner      <= w_winner_idx;
                        r_wdog       <= '0;
                        r_cor_enable <= 1'b1;
                        r_state      <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    r_wdog <= r_wdog + WD_W'(1);
                    // cor_done is tested first so it wins over a
                    // simultaneous watchdog expiry.
                    if (bus.cor_done) begin
                        r_x_out      <= bus.cor_x_out;
                        r_y_out      <= bus.cor_y_out;
                        r_z_out      <= bus.cor_z_out;
                        r_resp_valid <= w_owner_oh;
                        r_cor_enable <= 1'b0;
                        r_state      <= S_RESP;
                    end else if (r_wdog == C_WD_LAST) begin
                        // Results are left at their previous values.
                        r_resp_valid <= w_owner_oh;
                        r_resp_err   <= 1'b1;
                        r_cor_enable <= 1'b0;
                        r_state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_rr_ptr <= (r_owner == C_LAST_IDX) ? '0 : r_owner + IDX_W'(1);
                    r_state  <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.grant      = r_grant;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.x_out      = r_x_out;
    assign bus.y_out      = r_y_out;
    assign bus.z_out      = r_z_out;
    assign bus.cor_enable = r_cor_enable;
    assign bus.cor_select = r_cor_select;
    assign bus.cor_x_in   = r_cor_x;
    assign bus.cor_y_in   = r_cor_y;
    assign bus.cor_z_in   = r_cor_z;

endmodule
`default_nettype wire
